// File: rtl/i2c_slave_regs_if.sv
// Bus-side signals of the I2C register target: raw SCL/SDA levels in,
// open-drain SDA enable and register-write announcement out.
interface i2c_slave_regs_if #(
    parameter int PW = 4
);
    logic          scl_in;
    logic          sda_in;
    logic          sda_oe;
    logic          reg_wr_en;
    logic [PW-1:0] reg_wr_addr;
    logic [7:0]    reg_wr_data;
    logic          busy;

    modport slave (
        input  scl_in, sda_in,
        output sda_oe, reg_wr_en, reg_wr_addr, reg_wr_data, busy
    );

    modport master (
        output scl_in, sda_in,
        input  sda_oe, reg_wr_en, reg_wr_addr, reg_wr_data, busy
    );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target with a NUM_REGS x 8 register file: oversampled SCL/SDA, address
// match, register pointer, burst writes with a write strobe, burst reads.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 16
) (
    input  logic clk,
    input  logic reset_n,
    i2c_slave_regs_if.slave bus
);
    localparam int PW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t        state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [PW-1:0] ptr, ptr_n, ptr_inc;
    logic          rw, rw_n;
    logic          sda_oe_r, sda_oe_n;
    logic          busy_r, busy_n;
    logic          wr_en_r, wr_en_n;
    logic [PW-1:0] wr_addr_r, wr_addr_n;
    logic [7:0]    wr_data_r, wr_data_n;
    logic [7:0]    reg_file [NUM_REGS];

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] shift_in, rd_cur, rd_next;

    // Stage p0/p1: two-flop synchroniser; p2: history for edge/condition detect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
            sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= bus.scl_in; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
            sda_p0 <= bus.sda_in; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
    assign shift_in  = {shift[6:0], sda_p1};
    assign ptr_inc   = ptr + PW'(1);
    assign rd_cur    = reg_file[ptr];
    assign rd_next   = reg_file[ptr_inc];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_oe_r  <= 1'b0;
            busy_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            ptr       <= ptr_n;
            rw        <= rw_n;
            sda_oe_r  <= sda_oe_n;
            busy_r    <= busy_n;
            wr_en_r   <= wr_en_n;
            wr_addr_r <= wr_addr_n;
            wr_data_r <= wr_data_n;
            if (wr_en_n) reg_file[wr_addr_n] <= wr_data_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ptr_n     = ptr;
        rw_n      = rw;
        sda_oe_n  = sda_oe_r;
        busy_n    = busy_r;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_r;
        wr_data_n = wr_data_r;

        // Bus conditions pre-empt any SCL edge seen in the same cycle
        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else if (stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_n   = shift_in;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_n = '0;
                        rw_n      = sda_p1;
                        if (shift[6:0] == SLAVE_ADDR) begin
                            state_n = ADDR_ACK;
                            busy_n  = 1'b1;
                        end else begin
                            state_n = IGNORE;
                            busy_n  = 1'b0;
                        end
                    end
                end
                // First falling edge pulls SDA low, second one releases it
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (bit_cnt == 4'd0) begin
                        sda_oe_n  = 1'b1;
                        bit_cnt_n = 4'd1;
                    end else begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        if (state == ADDR_ACK && rw) begin
                            state_n   = RDATA;
                            shift_n   = {rd_cur[6:0], 1'b0};
                            sda_oe_n  = ~rd_cur[7];
                            bit_cnt_n = 4'd1;
                        end else if (state == ADDR_ACK) begin
                            state_n = PTR;
                        end else begin
                            state_n = WDATA;
                        end
                    end
                end
                PTR: if (scl_rise) begin
                    shift_n   = shift_in;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_n = '0;
                        ptr_n     = shift_in[PW-1:0];
                        state_n   = PTR_ACK;
                    end
                end
                WDATA: if (scl_rise) begin
                    shift_n   = shift_in;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_n = '0;
                        wr_en_n   = 1'b1;
                        wr_addr_n = ptr;
                        wr_data_n = shift_in;
                        ptr_n     = ptr_inc;
                        state_n   = WDATA_ACK;
                    end
                end
                // bit_cnt counts bits already placed on SDA
                RDATA: if (scl_fall) begin
                    if (bit_cnt < 4'd8) begin
                        sda_oe_n  = ~shift[7];
                        shift_n   = {shift[6:0], 1'b0};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = RDATA_ACK;
                    end
                end
                RDATA_ACK: if (scl_rise) begin
                    if (!sda_p1) begin
                        ptr_n     = ptr_inc;
                        shift_n   = rd_next;
                        bit_cnt_n = '0;
                        state_n   = RDATA;
                    end else begin
                        state_n = IGNORE;
                        busy_n  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe      = sda_oe_r;
    assign bus.busy        = busy_r;
    assign bus.reg_wr_en   = wr_en_r;
    assign bus.reg_wr_addr = wr_addr_r;
    assign bus.reg_wr_data = wr_data_r;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: an I2C master drives byte-level transactions while
// a transaction-level model predicts ACKs, read data, busy and write strobes.
module tb_i2c_slave_regs;
    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #5 clk = ~clk;

    i2c_slave_regs_if #(.PW(4)) bif ();
    assign bif.scl_in = scl_m;
    assign bif.sda_in = sda_m & ~bif.sda_oe;

    i2c_slave_regs #(.SLAVE_ADDR(7'h50), .NUM_REGS(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bif)
    );

    int total = 0;
    int passed = 0;

    // Model: register contents, pointer, protocol phase, expected busy.
    // mstate: 0 idle/ignored, 1 expecting address, 2 expecting pointer, 3 writing, 4 reading
    logic [7:0]  mregs [16];
    int          mptr = 0;
    int          mstate = 0;
    logic        mbusy = 1'b0;
    logic        mon_en = 1'b0;
    logic [11:0] expq [$];
    logic [3:0]  wl_addr [$];
    logic [7:0]  wl_data [$];
    logic        prev_wr = 1'b0;
    logic [11:0] exp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bif.reg_wr_en) begin
                check("wr_pulse_width", 32'(prev_wr), 0);
                if (expq.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    exp_e = expq.pop_front();
                    check("wr_addr", 32'(bif.reg_wr_addr), 32'(exp_e[11:8]));
                    check("wr_data", 32'(bif.reg_wr_data), 32'(exp_e[7:0]));
                end
                wl_addr.push_back(bif.reg_wr_addr);
                wl_data.push_back(bif.reg_wr_data);
            end
            if (mon_en && mstate == 0) check("sda_released", 32'(bif.sda_oe), 0);
        end
        prev_wr <= bif.reg_wr_en;
    end

    task automatic wait_q(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;   wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        s = bif.sda_in; wait_q(Q);
        scl_m = 1'b0; wait_q(Q);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        sda_m = 1'b0; wait_q(Q);
        scl_m = 1'b0; wait_q(Q);
    endtask

    task automatic m_start();
        bus_start();
        mstate = 1;
    endtask

    task automatic m_stop();
        sda_m = 1'b0; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        sda_m = 1'b1; wait_q(Q);
        mstate = 0;
        mbusy  = 1'b0;
        check("busy_after_stop", 32'(bif.busy), 0);
    endtask

    task automatic m_write_byte(input logic [7:0] b);
        logic s, ack_seen, exp_ack;
        exp_ack = 1'b0;
        case (mstate)
            1: begin
                mbusy = (b[7:1] == 7'h50);
                exp_ack = mbusy;
            end
            2: exp_ack = 1'b1;
            3: begin
                exp_ack = 1'b1;
                expq.push_back({4'(mptr), b});
            end
            default: exp_ack = 1'b0;
        endcase
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack_seen = ~s;
        check($sformatf("ack_byte_%02h", b), 32'(ack_seen), 32'(exp_ack));
        case (mstate)
            1: mstate = (b[7:1] == 7'h50) ? (b[0] ? 4 : 2) : 0;
            2: begin mptr = b % 16; mstate = 3; end
            3: begin mregs[mptr] = b; mptr = (mptr + 1) % 16; end
            default: ;
        endcase
        check($sformatf("busy_after_%02h", b), 32'(bif.busy), 32'(mbusy));
    endtask

    task automatic m_read_byte(input logic mack, input string nm, output logic [7:0] got);
        logic s;
        logic [7:0] exp;
        exp = mregs[mptr];
        got = '0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            got = {got[6:0], s};
        end
        clock_bit(~mack, s);
        check(nm, 32'(got), 32'(exp));
        if (mack) mptr = (mptr + 1) % 16;
        else begin mstate = 0; mbusy = 1'b0; end
        check({nm, "_busy"}, 32'(bif.busy), 32'(mbusy));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic s;
        logic [7:0] got;
        logic [7:0] a0;
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;

        // Power-on reset
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_sda_oe", 32'(bif.sda_oe), 0);
        check("rst_wr_en", 32'(bif.reg_wr_en), 0);
        check("rst_wr_addr", 32'(bif.reg_wr_addr), 0);
        check("rst_wr_data", 32'(bif.reg_wr_data), 0);
        check("rst_busy", 32'(bif.busy), 0);
        reset_n = 1'b1;
        wait_q(4);
        mon_en = 1'b1;

        // Reset while the slave is holding the address ACK
        mon_en = 1'b0;
        bus_start();
        a0 = 8'hA0;
        for (int i = 7; i >= 0; i--) clock_bit(a0[i], s);
        sda_m = 1'b1; wait_q(Q);
        scl_m = 1'b1; wait_q(Q / 2);
        check("ack_before_reset", 32'(bif.sda_oe), 1);
        check("busy_before_reset", 32'(bif.busy), 1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_mid_sda_oe", 32'(bif.sda_oe), 0);
        check("reset_mid_busy", 32'(bif.busy), 0);
        reset_n = 1'b1;
        wait_q(Q / 2);
        scl_m = 1'b0; wait_q(Q);
        mstate = 0; mptr = 0; mbusy = 1'b0;
        mon_en = 1'b1;

        // Burst write from pointer 3
        m_start(); m_write_byte(8'hA0); m_write_byte(8'h03);
        m_write_byte(8'h5A); m_write_byte(8'hC3); m_stop();
        check("wr_count", wl_addr.size(), 2);
        if (wl_addr.size() == 2) begin
            check("wr0_addr", 32'(wl_addr[0]), 3);  check("wr0_data", 32'(wl_data[0]), 'h5A);
            check("wr1_addr", 32'(wl_addr[1]), 4);  check("wr1_data", 32'(wl_data[1]), 'hC3);
        end
        wl_addr.delete(); wl_data.delete();

        // Pointer wraps modulo 16
        m_start(); m_write_byte(8'hA0); m_write_byte(8'h1F);
        m_write_byte(8'h11); m_write_byte(8'h22); m_stop();
        check("wrap_count", wl_addr.size(), 2);
        if (wl_addr.size() == 2) begin
            check("wrap0_addr", 32'(wl_addr[0]), 15); check("wrap0_data", 32'(wl_data[0]), 'h11);
            check("wrap1_addr", 32'(wl_addr[1]), 0);  check("wrap1_data", 32'(wl_data[1]), 'h22);
        end
        wl_addr.delete(); wl_data.delete();

        // Pointer write, repeated START, two-byte read ending in NACK
        m_start(); m_write_byte(8'hA0); m_write_byte(8'h03);
        m_start(); m_write_byte(8'hA1);
        m_read_byte(1'b1, "rd0", got);
        check("rd0_literal", 32'(got), 'h5A);
        m_read_byte(1'b0, "rd1", got);
        check("rd1_literal", 32'(got), 'hC3);
        m_write_byte(8'h00);
        m_stop();

        // Foreign address: no ACK, no writes
        m_start(); m_write_byte(8'h42); m_write_byte(8'h03); m_write_byte(8'h99); m_stop();
        check("mismatch_writes", wl_addr.size(), 0);

        // Write aborted after 4 data bits keeps the pointer
        m_start(); m_write_byte(8'hA0); m_write_byte(8'h02); m_write_byte(8'h77); m_stop();
        wl_addr.delete(); wl_data.delete();
        m_start(); m_write_byte(8'hA0); m_write_byte(8'h02);
        clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b0, s);
        m_stop();
        check("abort_writes", wl_addr.size(), 0);
        m_start(); m_write_byte(8'hA1);
        m_read_byte(1'b0, "rd_after_abort", got);
        check("abort_literal", 32'(got), 'h77);
        m_stop();

        wait_q(4);
        check("pending_writes", expq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
